// File: rtl/mismatch_tracker.sv
// Reference-vs-DUT compare checker: per-bit and total mismatch counts, first-error timestamps,
// and a valid/ready report stream. Define MISMATCH_TRACKER_SATURATE_EN for saturating counters.
module mismatch_tracker #(
    parameter int NOUT   = 3,
    parameter int CNT_W  = 16,
    parameter int TIME_W = 32
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              sample_valid,
    input  logic [NOUT-1:0]   ref_vec,
    input  logic [NOUT-1:0]   dut_vec,
    input  logic              clear,
    input  logic              rpt_start,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [TIME_W-1:0] rpt_data,
    output logic              rpt_last,
    output logic              busy
);

    localparam int NWORDS   = 3 + 2 * NOUT;
    localparam int IDX_W    = $clog2(NWORDS);
    localparam int WORDS_P2 = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TIME_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0]   samp_q, samp_d;
    logic [CNT_W-1:0]   tot_q, tot_d;
    logic [TIME_W-1:0]  tot_first_q, tot_first_d;
    logic               tot_seen_q, tot_seen_d;
    logic [NOUT-1:0]    diff;
    logic               accept;
    logic [TIME_W-1:0]  words [WORDS_P2];

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef MISMATCH_TRACKER_SATURATE_EN
        return (&v) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    assign busy   = (state_q == S_REPORT);
    assign diff   = ref_vec ^ dut_vec;
    // Sampling is suspended while reporting so the streamed words form one snapshot.
    assign accept = sample_valid && !busy && !clear;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (clear) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rpt_start) begin
                        state_d = S_REPORT;
                        idx_d   = '0;
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ts_d        = ts_q + 1'b1;
        samp_d      = samp_q;
        tot_d       = tot_q;
        tot_first_d = tot_first_q;
        tot_seen_d  = tot_seen_q;
        if (clear) begin
            ts_d        = '0;
            samp_d      = '0;
            tot_d       = '0;
            tot_first_d = '1;
            tot_seen_d  = 1'b0;
        end else if (accept) begin
            samp_d = cnt_inc(samp_q);
            if (|diff) begin
                tot_d = cnt_inc(tot_q);
                if (!tot_seen_q) begin
                    tot_first_d = ts_q;
                    tot_seen_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ts_q        <= '0;
            samp_q      <= '0;
            tot_q       <= '0;
            tot_first_q <= '1;
            tot_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ts_q        <= ts_d;
            samp_q      <= samp_d;
            tot_q       <= tot_d;
            tot_first_q <= tot_first_d;
            tot_seen_q  <= tot_seen_d;
        end
    end

    assign words[0] = TIME_W'(samp_q);
    assign words[1] = TIME_W'(tot_q);
    assign words[2] = tot_first_q;

    for (genvar gi = 0; gi < NOUT; gi++) begin : g_bit
        logic [CNT_W-1:0]  err_q, err_d;
        logic [TIME_W-1:0] first_q, first_d;
        // Separate "seen" flag: an all-ones timestamp is also a legal first-error time.
        logic              seen_q, seen_d;

        always_comb begin
            err_d   = err_q;
            first_d = first_q;
            seen_d  = seen_q;
            if (clear) begin
                err_d   = '0;
                first_d = '1;
                seen_d  = 1'b0;
            end else if (accept && diff[gi]) begin
                err_d = cnt_inc(err_q);
                if (!seen_q) begin
                    first_d = ts_q;
                    seen_d  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge areset_n) begin
            if (!areset_n) begin
                err_q   <= '0;
                first_q <= '1;
                seen_q  <= 1'b0;
            end else begin
                err_q   <= err_d;
                first_q <= first_d;
                seen_q  <= seen_d;
            end
        end

        assign words[3 + 2 * gi] = TIME_W'(err_q);
        assign words[4 + 2 * gi] = first_q;
    end

    for (genvar gi = NWORDS; gi < WORDS_P2; gi++) begin : g_pad
        assign words[gi] = '0;
    end

    assign rpt_valid = busy;
    assign rpt_last  = busy && (idx_q == LAST_IDX);
    assign rpt_data  = busy ? words[idx_q] : '0;

endmodule

// File: tb/tb_mismatch_tracker.sv
// Scoreboard bench for mismatch_tracker (NOUT=3, CNT_W=8, TIME_W=32): directed samples,
// expected report words queued by the stimulus, popped and compared by a monitor.
module tb_mismatch_tracker;

    localparam int NOUT   = 3;
    localparam int CNT_W  = 8;
    localparam int TIME_W = 32;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic              clk;
    logic              areset_n;
    logic              sample_valid;
    logic [NOUT-1:0]   ref_vec;
    logic [NOUT-1:0]   dut_vec;
    logic              clear;
    logic              rpt_start;
    logic              rpt_valid;
    logic              rpt_ready;
    logic [TIME_W-1:0] rpt_data;
    logic              rpt_last;
    logic              busy;

    mismatch_tracker #(.NOUT(NOUT), .CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .sample_valid (sample_valid),
        .ref_vec      (ref_vec),
        .dut_vec      (dut_vec),
        .clear        (clear),
        .rpt_start    (rpt_start),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_data     (rpt_data),
        .rpt_last     (rpt_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_w[9];
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every handshake pops one expected word; a stalled word must stay put.
    logic [31:0] held_data;
    logic        held_last;
    bit          held = 0;
    always @(negedge clk) begin
        if (areset_n && rpt_valid && held) begin
            check("hold_data", rpt_data, held_data);
            check("hold_last", {31'd0, rpt_last}, {31'd0, held_last});
        end
        held = 0;
        if (areset_n && rpt_valid && rpt_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: got %h, want none", rpt_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("word%0d_data", e.idx), rpt_data, e.data);
                check($sformatf("word%0d_last", e.idx), {31'd0, rpt_last}, {31'd0, e.last});
            end
        end else if (areset_n && rpt_valid) begin
            held      = 1;
            held_data = rpt_data;
            held_last = rpt_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_report(input logic [31:0] s, input logic [31:0] t, input logic [31:0] tts,
                              input logic [31:0] e0, input logic [31:0] t0,
                              input logic [31:0] e1, input logic [31:0] t1,
                              input logic [31:0] e2, input logic [31:0] t2);
        exp_w[0] = s;  exp_w[1] = t;  exp_w[2] = tts;
        exp_w[3] = e0; exp_w[4] = t0;
        exp_w[5] = e1; exp_w[6] = t1;
        exp_w[7] = e2; exp_w[8] = t2;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = exp_w[i];
            e.last = (i == 8);
            e.idx  = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_samples(input logic [2:0] r, input logic [2:0] d, input int n,
                                 input int mis_at, input logic [2:0] dmis);
        for (int k = 0; k < n; k++) begin
            sample_valid = 1'b1;
            ref_vec      = r;
            dut_vec      = (k == mis_at) ? dmis : d;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    // Runs one report; optional stall on a word, junk samples while busy,
    // clear-abort or asynchronous-reset abort when a given word is presented.
    task automatic run_report(input int stall_word, input int stall_cycles, input bit junk,
                              input int abort_word, input int reset_word);
        int  hs;
        int  stalls;
        bit  done;
        bit  aborted;
        hs = 0; stalls = 0; done = 0; aborted = 0;
        rpt_start = 1'b1;
        tick();
        rpt_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            rpt_ready    = 1'b1;
            sample_valid = junk;
            ref_vec      = 3'b000;
            dut_vec      = 3'b111;
            if (hs == stall_word && stalls < stall_cycles) begin
                rpt_ready = 1'b0;
                stalls++;
            end
            if (hs == reset_word) begin
                rpt_ready = 1'b0;
                areset_n  = 1'b0;
                #1;
                check("rst_mid_valid", {31'd0, rpt_valid}, 32'd0);
                check("rst_mid_last",  {31'd0, rpt_last},  32'd0);
                check("rst_mid_data",  rpt_data,           32'd0);
                check("rst_mid_busy",  {31'd0, busy},      32'd0);
                done = 1;
            end else begin
                if (hs == abort_word) begin
                    clear     = 1'b1;
                    rpt_ready = 1'b0;
                end
                @(negedge clk);
                if (rpt_valid && rpt_ready) begin
                    if (rpt_last) done = 1;
                    hs++;
                end
                tick();
                if (clear) begin
                    clear   = 1'b0;
                    done    = 1;
                    aborted = 1;
                end
            end
        end
        sample_valid = 1'b0;
        rpt_ready    = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL report_timeout: got %0d words, want 9", hs);
        end else if (areset_n) begin
            @(negedge clk);
            check(aborted ? "abort_busy" : "end_busy",  {31'd0, busy},      32'd0);
            check(aborted ? "abort_valid" : "end_valid", {31'd0, rpt_valid}, 32'd0);
            tick();
        end
    endtask

    initial begin
        areset_n     = 1'b0;
        sample_valid = 1'b0;
        ref_vec      = '0;
        dut_vec      = '0;
        clear        = 1'b0;
        rpt_start    = 1'b0;
        rpt_ready    = 1'b0;
        repeat (3) tick();
        check("rst_valid", {31'd0, rpt_valid}, 32'd0);
        check("rst_last",  {31'd0, rpt_last},  32'd0);
        check("rst_data",  rpt_data,           32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        areset_n = 1'b1;

        // Empty report straight after reset.
        set_report(0, 0, NONE, 0, NONE, 0, NONE, 0, NONE);
        push_words(9);
        run_report(-1, 0, 0, -1, -1);

        // Fresh reset so the timestamp restarts: sample k lands on timestamp k.
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        drive_samples(3'b110, 3'b110, 10, 4, 3'b011);
        set_report(10, 1, 4, 1, 4, 0, NONE, 1, 4);
        push_words(9);
        run_report(-1, 0, 0, -1, -1);

        // Stall on word 2 with mismatching samples offered while busy.
        push_words(9);
        run_report(2, 3, 1, -1, -1);
        push_words(9);
        run_report(-1, 0, 0, -1, -1);

        // Clear aborts the report at word 5.
        push_words(5);
        run_report(-1, 0, 0, 5, -1);
        set_report(0, 0, NONE, 0, NONE, 0, NONE, 0, NONE);
        push_words(9);
        run_report(-1, 0, 0, -1, -1);

        // rpt_start together with clear: stays idle, stats wiped.
        drive_samples(3'b000, 3'b101, 3, -1, 3'b000);
        rpt_start = 1'b1;
        clear     = 1'b1;
        tick();
        rpt_start = 1'b0;
        clear     = 1'b0;
        @(negedge clk);
        check("startclr_busy",  {31'd0, busy},      32'd0);
        check("startclr_valid", {31'd0, rpt_valid}, 32'd0);
        tick();
        push_words(9);
        run_report(-1, 0, 0, -1, -1);

        // 300 bit-0 mismatches against an 8-bit counter.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive_samples(3'b000, 3'b001, 300, -1, 3'b000);
`ifdef MISMATCH_TRACKER_SATURATE_EN
        set_report(255, 255, 0, 255, 0, 0, NONE, 0, NONE);
`else
        set_report(44, 44, 0, 44, 0, 0, NONE, 0, NONE);
`endif
        push_words(9);
        run_report(-1, 0, 0, -1, -1);

        // Asynchronous reset while word 3 is presented.
        push_words(3);
        run_report(-1, 0, 0, -1, 3);
        tick();
        areset_n = 1'b1;
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
